logic_op_sequencer: RTL

- Sequential command front-end for the team's combinational logic-operation unit (AND/OR/XOR/NOT A, opcode-selected, zero for unlisted opcodes).
- Accepts commands over a valid/ready interface and drives registered operands and opcode into an external logic unit instance.
- Captures the unit's result and returns it, with status flags, over a valid/ready response interface.
- Supports chained operation: operand A is replaced by the previous result.

---
 rtl/logic_op_sequencer_if.sv | 31 +++
 rtl/logic_op_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/logic_op_sequencer_if.sv
// Command and response handshake bundle for logic_op_sequencer.
interface logic_op_sequencer_if #(
    parameter int unsigned N = 16
) ();
    // command channel
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_opcode;
    logic [N-1:0]  cmd_a;
    logic [N-1:0]  cmd_b;
    logic          cmd_chain;

    // response channel
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_data;
    logic          rsp_zero;
    logic          rsp_illegal;

    // issuer of commands, consumer of responses
    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_chain, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_illegal
    );

    // the sequencer side
    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_chain, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_illegal
    );
endinterface

// File: rtl/logic_op_sequencer.sv
// Command front-end for the combinational logic unit: registers operands,
// captures the unit's result one cycle later and returns it with flags.
module logic_op_sequencer #(
    parameter int unsigned N = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    logic_op_sequencer_if.slave    bus,
    output logic [N-1:0]           lu_a,
    output logic [N-1:0]           lu_b,
    output logic [2:0]             lu_opcode,
    input  logic [N-1:0]           lu_out,
    output logic [7:0]             op_count
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          accept_c;
    logic          capture_c;
    logic          deliver_c;
    logic          illegal_c;
    logic          illegal_q;
    logic [N-1:0]  last_result;

    // opcode outside the unit's defined set
    assign illegal_c = !(bus.cmd_opcode inside {OP_AND, OP_OR, OP_XOR, OP_NOT});

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state and handshake decode
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        deliver_c = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture_c = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    deliver_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // registered handshake outputs, tracking the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
        end else begin
            bus.cmd_ready <= (state_nxt == IDLE);
            bus.rsp_valid <= (state_nxt == RESP);
        end
    end

    // operand issue, result capture and completion count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_a            <= '0;
            lu_b            <= '0;
            lu_opcode       <= 3'b000;
            illegal_q       <= 1'b0;
            last_result     <= '0;
            bus.rsp_data    <= '0;
            bus.rsp_zero    <= 1'b0;
            bus.rsp_illegal <= 1'b0;
            op_count        <= 8'd0;
        end else begin
            if (accept_c) begin
                lu_a      <= bus.cmd_chain ? last_result : bus.cmd_a;
                lu_b      <= bus.cmd_b;
                lu_opcode <= bus.cmd_opcode;
                illegal_q <= illegal_c;
            end
            if (capture_c) begin
                bus.rsp_data    <= lu_out;
                last_result     <= lu_out;
                bus.rsp_zero    <= (lu_out == '0);
                bus.rsp_illegal <= illegal_q;
            end
            if (deliver_c) begin
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule
